// File: rtl/airlock_pkg.sv
// Shared types and default timing constants for the airlock chamber controller.
package airlock_pkg;

    // Chamber/door states; P_* side is habitat pressure, V_* side is vacuum.
    typedef enum logic [2:0] {
        P_IDLE   = 3'd0,
        IN_OPEN  = 3'd1,
        EVAC     = 3'd2,
        V_IDLE   = 3'd3,
        OUT_OPEN = 3'd4,
        PRESS    = 3'd5
    } state_t;

    localparam int EVAC_CYCLES_DEF  = 8;
    localparam int PRESS_CYCLES_DEF = 7;
    localparam int CNT_W_DEF        = 4;

endpackage

// File: rtl/airlock_sequencer_rise_detect.sv
// Rising-edge detector for a debounced level request.
module rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic rise
);

    logic prev;

    // prev resets high so a request already held through reset cannot fire.
    always_ff @(posedge Clock) begin
        if (Reset) prev <= 1'b1;
        else       prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: door gating, evacuate/pressurize timing, Moore outputs.
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int EVAC_CYCLES  = EVAC_CYCLES_DEF,
    parameter int PRESS_CYCLES = PRESS_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InnerCmd,
    input  logic             OuterCmd,
    input  logic             EvacReq,
    input  logic             PressReq,
    output logic             InnerDoorOpen,
    output logic             OuterDoorOpen,
    output logic             Evacuating,
    output logic             Pressurizing,
    output logic             Pressurized,
    output logic [CNT_W-1:0] CountOut
);

    localparam logic [CNT_W-1:0] EVAC_LOAD  = CNT_W'(EVAC_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             evac_rise, press_rise;

    rise_detect u_evac_rise (
        .Clock (Clock),
        .Reset (Reset),
        .d     (EvacReq),
        .rise  (evac_rise)
    );

    rise_detect u_press_rise (
        .Clock (Clock),
        .Reset (Reset),
        .d     (PressReq),
        .rise  (press_rise)
    );

    // State and phase counter registers; reset always lands pressurized with doors shut.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= P_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state logic: door commands beat edges in idle states, aborts beat completion in timed phases.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            P_IDLE: begin
                if (InnerCmd) begin
                    state_next = IN_OPEN;
                end else if (evac_rise) begin
                    state_next = EVAC;
                    count_next = EVAC_LOAD;
                end
            end
            IN_OPEN: begin
                if (!InnerCmd) state_next = P_IDLE;
            end
            EVAC: begin
                if (press_rise) begin
                    state_next = PRESS;
                    count_next = PRESS_LOAD;
                end else if (count == '0) begin
                    state_next = V_IDLE;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            V_IDLE: begin
                if (OuterCmd) begin
                    state_next = OUT_OPEN;
                end else if (press_rise) begin
                    state_next = PRESS;
                    count_next = PRESS_LOAD;
                end
            end
            OUT_OPEN: begin
                if (!OuterCmd) state_next = V_IDLE;
            end
            PRESS: begin
                if (evac_rise) begin
                    state_next = EVAC;
                    count_next = EVAC_LOAD;
                end else if (count == '0) begin
                    state_next = P_IDLE;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            default: begin
                state_next = P_IDLE;
                count_next = '0;
            end
        endcase
    end

    // Moore output decode from the state register only.
    assign InnerDoorOpen = (state == IN_OPEN);
    assign OuterDoorOpen = (state == OUT_OPEN);
    assign Evacuating    = (state == EVAC);
    assign Pressurizing  = (state == PRESS);
    assign Pressurized   = (state == P_IDLE) || (state == IN_OPEN);
    assign CountOut      = (state == EVAC || state == PRESS) ? count : '0;

endmodule
